// File: rtl/arlet6502_bus_pkg.sv
// Shared definitions for the 6502 memory-side bus bridge: bus widths,
// default open-bus value and the transaction state encoding.
package arlet6502_bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] OPEN_BUS_DEFAULT = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } bus_state_e;

endpackage : arlet6502_bus_pkg

// File: rtl/arlet6502_bus_timeout.sv
// Wait-cycle counter for the bus bridge. Cleared while no request is
// outstanding, advanced on every unacknowledged REQ cycle, and flags the
// terminal count when the current cycle is the last one allowed.
module arlet6502_bus_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: clear has priority, otherwise step when enabled.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 8'd0;
      end else if (en_i) begin
         count_d = count_q + 8'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == TC_VAL);

endmodule : arlet6502_bus_timeout

// File: rtl/arlet6502_bus_bridge.sv
// Bus bridge between the 6502 core and a variable-latency request/ack bus.
// Every ready cycle the core's address/data/we are captured and one
// external transaction is run; the core is stalled (cpu_rdy=0) until the
// access is accepted or aborted by the timeout, which also raises a
// sticky bus error.
module arlet6502_bus_bridge
   import arlet6502_bus_pkg::*;
#(
   parameter int                TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] OPEN_BUS = OPEN_BUS_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_a,
   input  logic [DATA_W-1:0] cpu_do,
   input  logic              cpu_we,
   output logic [DATA_W-1:0] cpu_di,
   output logic              cpu_rdy,
   output logic              ext_req,
   output logic [ADDR_W-1:0] ext_addr,
   output logic              ext_we,
   output logic [DATA_W-1:0] ext_wdata,
   input  logic [DATA_W-1:0] ext_rdata,
   input  logic              ext_ack,
   output logic              bus_err,
   input  logic              bus_err_clr
);

   bus_state_e        state_q,     state_d;
   logic              rdy_q,       rdy_d;
   logic [DATA_W-1:0] cpu_di_q,    cpu_di_d;
   logic              ext_req_q,   ext_req_d;
   logic [ADDR_W-1:0] ext_addr_q,  ext_addr_d;
   logic              ext_we_q,    ext_we_d;
   logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
   logic              bus_err_q,   bus_err_d;

   logic in_req_s;
   logic accept_s;
   logic abort_s;
   logic tc_s;

   assign in_req_s = (state_q == ST_REQ);
   assign accept_s = in_req_s && ext_ack;
   assign abort_s  = in_req_s && !ext_ack && tc_s;

   arlet6502_bus_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clr_i (!in_req_s),
      .en_i  (in_req_s && !ext_ack),
      .tc_o  (tc_s)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: every ready cycle starts an access; REQ ends on accept or abort.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (accept_s || abort_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output next-values: capture the core request, return data, track bus error.
   always_comb begin
      cpu_di_d    = cpu_di_q;
      ext_req_d   = ext_req_q;
      ext_addr_d  = ext_addr_q;
      ext_we_d    = ext_we_q;
      ext_wdata_d = ext_wdata_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            ext_addr_d  = cpu_a;
            ext_we_d    = cpu_we;
            ext_wdata_d = cpu_do;
            ext_req_d   = 1'b1;
         end
         ST_REQ: begin
            if (accept_s) begin
               ext_req_d = 1'b0;
               if (!ext_we_q) begin
                  cpu_di_d = ext_rdata;
               end else begin
                  cpu_di_d = cpu_di_q;
               end
            end else if (abort_s) begin
               ext_req_d = 1'b0;
               if (!ext_we_q) begin
                  cpu_di_d = OPEN_BUS;
               end else begin
                  cpu_di_d = cpu_di_q;
               end
            end else begin
               ext_req_d = 1'b1;
            end
         end
         default: begin
            ext_req_d = 1'b0;
         end
      endcase

      // Abort sets the error even if a clear arrives on the same edge.
      if (abort_s) begin
         bus_err_d = 1'b1;
      end else if (bus_err_clr) begin
         bus_err_d = 1'b0;
      end else begin
         bus_err_d = bus_err_q;
      end

      // Ready comes from its own flop so the core sees a glitch-free level.
      rdy_d = (state_d != ST_REQ);
   end

   // Registered outputs toward the core and the external bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q       <= 1'b1;
         cpu_di_q    <= '0;
         ext_req_q   <= 1'b0;
         ext_addr_q  <= '0;
         ext_we_q    <= 1'b0;
         ext_wdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         rdy_q       <= rdy_d;
         cpu_di_q    <= cpu_di_d;
         ext_req_q   <= ext_req_d;
         ext_addr_q  <= ext_addr_d;
         ext_we_q    <= ext_we_d;
         ext_wdata_q <= ext_wdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign cpu_rdy   = rdy_q;
   assign cpu_di    = cpu_di_q;
   assign ext_req   = ext_req_q;
   assign ext_addr  = ext_addr_q;
   assign ext_we    = ext_we_q;
   assign ext_wdata = ext_wdata_q;
   assign bus_err   = bus_err_q;

endmodule : arlet6502_bus_bridge

// File: tb/tb_arlet6502_bus_bridge.sv
// Scoreboard bench for the 6502 bus bridge. The driver plays both the core
// and the external slave, pushing the expected completion of each access;
// a monitor checks request stability during REQ and pops/compares on DONE.
module tb_arlet6502_bus_bridge;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_do;
   logic        cpu_we;
   logic [7:0]  cpu_di;
   logic        cpu_rdy;
   logic        ext_req;
   logic [15:0] ext_addr;
   logic        ext_we;
   logic [7:0]  ext_wdata;
   logic [7:0]  ext_rdata;
   logic        ext_ack;
   logic        bus_err;
   logic        bus_err_clr;

   always #5 clk = ~clk;

   arlet6502_bus_bridge #(
      .TIMEOUT  (TO),
      .OPEN_BUS (8'hFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_a       (cpu_a),
      .cpu_do      (cpu_do),
      .cpu_we      (cpu_we),
      .cpu_di      (cpu_di),
      .cpu_rdy     (cpu_rdy),
      .ext_req     (ext_req),
      .ext_addr    (ext_addr),
      .ext_we      (ext_we),
      .ext_wdata   (ext_wdata),
      .ext_rdata   (ext_rdata),
      .ext_ack     (ext_ack),
      .bus_err     (bus_err),
      .bus_err_clr (bus_err_clr)
   );

   typedef struct {
      logic [7:0]  di;
      logic        err;
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
      int          ncyc;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  slave_mem [0:65535];
   logic [7:0]  ref_mem   [0:65535];
   logic [7:0]  di_model  = 8'h00;
   logic        err_model = 1'b0;
   logic        mon_en    = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: request stability during REQ, completion compare on DONE.
   initial begin : monitor
      logic       prev_rdy;
      int         req_cnt;
      logic [7:0] last_di;
      exp_t       e;
      prev_rdy = 1'b1;
      req_cnt  = 0;
      last_di  = 8'h00;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            prev_rdy = 1'b1;
         end else if (reset !== 1'b1) begin
            prev_rdy = 1'b1;
            req_cnt  = 0;
            last_di  = 8'h00;
         end else if (cpu_rdy === 1'b0) begin
            req_cnt++;
            check("req_held", 32'(ext_req), 32'd1);
            check("di_hold", 32'(cpu_di), 32'(last_di));
            if (exp_q.size() > 0) begin
               check("addr_stable", 32'(ext_addr), 32'(exp_q[0].addr));
               check("we_stable", 32'(ext_we), 32'(exp_q[0].we));
               check("wdata_stable", 32'(ext_wdata), 32'(exp_q[0].wdata));
            end
            prev_rdy = 1'b0;
         end else begin
            if (prev_rdy == 1'b0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("done_di", 32'(cpu_di), 32'(e.di));
                  check("done_err", 32'(bus_err), 32'(e.err));
                  check("req_cycles", 32'(req_cnt), 32'(e.ncyc));
                  check("done_req_low", 32'(ext_req), 32'd0);
                  last_di = e.di;
               end
            end
            prev_rdy = 1'b1;
            req_cnt  = 0;
         end
      end
   end

   task automatic poke(input logic [15:0] a, input logic [7:0] v);
      slave_mem[a] = v;
      ref_mem[a]   = v;
   endtask

   // One core access: d wait cycles before ack (d >= TO means no ack, abort).
   task automatic access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                         input int d, input logic clr, input logic stray);
      exp_t        e;
      logic        acked;
      logic [15:0] sa;
      logic        swe;
      logic [7:0]  sw;
      acked  = (d < TO);
      cpu_a  = a;
      cpu_we = we;
      cpu_do = wd;
      if (acked) begin
         if (we) ref_mem[a] = wd;
         else    di_model   = ref_mem[a];
      end else begin
         if (!we) di_model = 8'hFF;
      end
      if (!acked)   err_model = 1'b1;
      else if (clr) err_model = 1'b0;
      e.di    = di_model;
      e.err   = err_model;
      e.addr  = a;
      e.we    = we;
      e.wdata = wd;
      e.ncyc  = acked ? d + 1 : TO;
      exp_q.push_back(e);
      @(posedge clk); #1;
      ext_ack   = 1'b0;
      ext_rdata = 8'h00;
      if (acked) begin
         repeat (d) begin @(posedge clk); #1; end
         bus_err_clr = clr;
         sa  = ext_addr;
         swe = ext_we;
         sw  = ext_wdata;
         ext_rdata = slave_mem[sa];
         ext_ack   = 1'b1;
         @(posedge clk); #1;
         if (swe) slave_mem[sa] = sw;
         ext_ack     = stray;
         ext_rdata   = stray ? 8'hEE : 8'h00;
         bus_err_clr = 1'b0;
      end else begin
         repeat (TO - 1) begin @(posedge clk); #1; end
         bus_err_clr = clr;
         @(posedge clk); #1;
         bus_err_clr = 1'b0;
      end
   endtask

   initial begin : driver
      logic [15:0] ia;
      for (int i = 0; i < 65536; i++) begin
         ia = 16'(i);
         slave_mem[i] = ia[7:0] ^ ia[15:8] ^ 8'h5C;
         ref_mem[i]   = ia[7:0] ^ ia[15:8] ^ 8'h5C;
      end
      reset       = 1'b0;
      cpu_a       = 16'hFFFC;
      cpu_do      = 8'h00;
      cpu_we      = 1'b0;
      ext_ack     = 1'b0;
      ext_rdata   = 8'h00;
      bus_err_clr = 1'b0;

      // Reset values while held in reset.
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", 32'(cpu_rdy), 32'd1);
      check("rst_req", 32'(ext_req), 32'd0);
      check("rst_di", 32'(cpu_di), 32'h00);
      check("rst_addr", 32'(ext_addr), 32'h0000);
      check("rst_err", 32'(bus_err), 32'd0);
      reset = 1'b1;
      check("rdy_before_first_edge", 32'(cpu_rdy), 32'd1);

      // Reset vector fetch, then zero-wait reads (rdy pattern 0,1,...).
      access(16'hFFFC, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      poke(16'h1000, 8'hA9);
      access(16'h1000, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      access(16'h1001, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      access(16'h1002, 1'b0, 8'h00, 0, 1'b0, 1'b0);

      // Wait-state write (4 REQ cycles, cpu_di unchanged), then read back.
      access(16'h0200, 1'b1, 8'h5A, 3, 1'b0, 1'b0);
      access(16'h0200, 1'b0, 8'h00, 0, 1'b0, 1'b0);

      // Ack left high through DONE must be ignored.
      poke(16'h0201, 8'h11);
      access(16'h0201, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      access(16'h0202, 1'b0, 8'h00, 1, 1'b0, 1'b0);

      // Timeout on a read: open-bus data, sticky error.
      access(16'h0300, 1'b0, 8'h00, TO, 1'b0, 1'b0);
      access(16'h0301, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      access(16'h0302, 1'b1, 8'h33, 2, 1'b0, 1'b0);
      access(16'h0303, 1'b0, 8'h00, 0, 1'b1, 1'b0);
      // Clear on the same edge as a new abort: set wins.
      access(16'h0305, 1'b0, 8'h00, TO, 1'b1, 1'b0);
      access(16'h0306, 1'b0, 8'h00, 1, 1'b1, 1'b0);
      // Aborted write is dropped; read-back shows old contents.
      access(16'h0304, 1'b1, 8'h77, 9, 1'b0, 1'b0);
      access(16'h0304, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      access(16'h0400, 1'b0, 8'h00, TO, 1'b0, 1'b0);

      // Reset during REQ cycle 2.
      cpu_a  = 16'h0310;
      cpu_we = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_req", 32'(ext_req), 32'd0);
      check("mid_rst_rdy", 32'(cpu_rdy), 32'd1);
      check("mid_rst_di", 32'(cpu_di), 32'h00);
      check("mid_rst_addr", 32'(ext_addr), 32'h0000);
      check("mid_rst_we", 32'(ext_we), 32'd0);
      check("mid_rst_wdata", 32'(ext_wdata), 32'h00);
      check("mid_rst_err", 32'(bus_err), 32'd0);
      di_model  = 8'h00;
      err_model = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      access(16'h0310, 1'b0, 8'h00, 1, 1'b0, 1'b0);

      // Random back-to-back traffic over a small address window.
      for (int n = 0; n < 1000; n++) begin
         access(16'h0400 + 16'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)),
                int'($urandom_range(0, 10)),
                1'($urandom_range(0, 7) == 0),
                1'b0);
      end

      // Let the last completion be compared, then stop monitoring.
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_arlet6502_bus_bridge
